// File: rtl/vga_pkg.sv
// Shared VGA types: coordinate and colour widths, screen defaults, sprite FSM states.
package vga_pkg;

  localparam int COORD_W          = 12;
  localparam int COLOR_W          = 10;
  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [COORD_W:0]   scoord_t;
  typedef logic [COLOR_W-1:0]        color_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_CLAMP = 2'd2
  } state_t;

  // Signed per-axis displacement; opposite requests cancel.
  function automatic scoord_t stepDelta(input logic inc, input logic dec, input scoord_t step);
    scoord_t delta;
    if (inc && !dec) begin
      delta = step;
    end else if (dec && !inc) begin
      delta = -step;
    end else begin
      delta = 13'sd0;
    end
    return delta;
  endfunction

endpackage

// File: rtl/vga_axis_clamp.sv
// Clamps a signed 13-bit candidate coordinate into [minVal, maxVal] and flags when clamping occurred.
module vga_axis_clamp
  import vga_pkg::*;
(
  input  logic signed [12:0] cand,
  input  logic [11:0]        minVal,
  input  logic [11:0]        maxVal,
  output logic [11:0]        value,
  output logic               clamped
);

  scoord_t minS;
  scoord_t maxS;

  assign minS = $signed({1'b0, minVal});
  assign maxS = $signed({1'b0, maxVal});

  // Landing exactly on a limit passes through unclamped.
  always_comb begin
    value   = 12'd0;
    clamped = 1'b0;
    if (cand < minS) begin
      value   = minVal;
      clamped = 1'b1;
    end else if (cand > maxS) begin
      value   = maxVal;
      clamped = 1'b1;
    end else begin
      value   = cand[11:0];
      clamped = 1'b0;
    end
  end

endmodule

// File: rtl/vga_box_sprite.sv
// Frame-synchronous box sprite: moves/clamps a rectangle once per frame and renders it with 1-cycle latency.
// Optional blinking is enabled by defining VGA_BOX_SPRITE_BLINK_EN.
module vga_box_sprite
  import vga_pkg::*;
#(
  parameter int           BOX_W        = 10,
  parameter int           BOX_H        = 200,
  parameter int           SCREEN_W     = SCREEN_W_DEFAULT,
  parameter int           SCREEN_H     = SCREEN_H_DEFAULT,
  parameter int           STEP         = 4,
  parameter int           INIT_X       = 0,
  parameter int           INIT_Y       = 0,
  parameter logic [9:0]   COLOR_R      = 10'h3ff,
  parameter logic [9:0]   COLOR_G      = 10'h3ff,
  parameter logic [9:0]   COLOR_B      = 10'h3ff,
  parameter int           BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        move_left,
  input  logic        move_right,
  input  logic [11:0] counterX,
  input  logic [11:0] counterY,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        in_box,
  output logic        edge_hit,
  output logic [9:0]  vga_r,
  output logic [9:0]  vga_g,
  output logic [9:0]  vga_b
);

  localparam coord_t      MAX_X  = coord_t'(SCREEN_W - BOX_W);
  localparam coord_t      MAX_Y  = coord_t'(SCREEN_H - BOX_H);
  localparam coord_t      INIT_XC = coord_t'(INIT_X);
  localparam coord_t      INIT_YC = coord_t'(INIT_Y);
  localparam scoord_t     STEP_S = scoord_t'(STEP);
  localparam logic [12:0] BOX_W13 = 13'(BOX_W);
  localparam logic [12:0] BOX_H13 = 13'(BOX_H);

  // Elaboration-time sanity checks on the geometry.
  if (BOX_W < 2 || BOX_H < 2 || BOX_W > SCREEN_W || BOX_H > SCREEN_H) begin : gBadBox
    $error("vga_box_sprite: box does not fit the screen");
  end
  if (STEP < 1 || STEP > SCREEN_W - BOX_W || BLINK_FRAMES < 1) begin : gBadStep
    $error("vga_box_sprite: STEP or BLINK_FRAMES out of range");
  end
  if (INIT_X < 0 || INIT_X > SCREEN_W - BOX_W || INIT_Y < 0 || INIT_Y > SCREEN_H - BOX_H) begin : gBadInit
    $error("vga_box_sprite: reset position outside clamp range");
  end

  state_t  state_r;
  state_t  stateNext_s;
  logic    latchEn_s;
  logic    stepEn_s;
  logic    commitEn_s;

  logic    dirUp_r;
  logic    dirDown_r;
  logic    dirLeft_r;
  logic    dirRight_r;

  scoord_t candX_r;
  scoord_t candY_r;
  coord_t  clampX_s;
  coord_t  clampY_s;
  logic    clampedX_s;
  logic    clampedY_s;

  coord_t  posX_r;
  coord_t  posY_r;
  logic    edgeHit_r;

  logic    inside_s;
  logic    visible_s;
  logic    inBox_r;
  color_t  vgaR_r;
  color_t  vgaG_r;
  color_t  vgaB_r;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // FSM next-state logic; ticks outside S_IDLE are dropped.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (frame_tick) begin
          stateNext_s = S_STEP;
        end else begin
          stateNext_s = S_IDLE;
        end
      end
      S_STEP:  stateNext_s = S_CLAMP;
      S_CLAMP: stateNext_s = S_IDLE;
      default: stateNext_s = S_IDLE;
    endcase
  end

  // FSM output strobes.
  always_comb begin
    latchEn_s  = 1'b0;
    stepEn_s   = 1'b0;
    commitEn_s = 1'b0;
    case (state_r)
      S_IDLE:  latchEn_s  = frame_tick;
      S_STEP:  stepEn_s   = 1'b1;
      S_CLAMP: commitEn_s = 1'b1;
      default: begin
        latchEn_s  = 1'b0;
        stepEn_s   = 1'b0;
        commitEn_s = 1'b0;
      end
    endcase
  end

  // Direction requests captured on the accepted frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirUp_r    <= 1'b0;
      dirDown_r  <= 1'b0;
      dirLeft_r  <= 1'b0;
      dirRight_r <= 1'b0;
    end else if (latchEn_s) begin
      dirUp_r    <= move_up;
      dirDown_r  <= move_down;
      dirLeft_r  <= move_left;
      dirRight_r <= move_right;
    end
  end

  // Unclamped signed candidates so a step past zero is detectable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      candX_r <= 13'sd0;
      candY_r <= 13'sd0;
    end else if (stepEn_s) begin
      candX_r <= $signed({1'b0, posX_r}) + stepDelta(dirRight_r, dirLeft_r, STEP_S);
      candY_r <= $signed({1'b0, posY_r}) + stepDelta(dirDown_r, dirUp_r, STEP_S);
    end
  end

  vga_axis_clamp uClampX (
    .cand    (candX_r),
    .minVal  (12'd0),
    .maxVal  (MAX_X),
    .value   (clampX_s),
    .clamped (clampedX_s)
  );

  vga_axis_clamp uClampY (
    .cand    (candY_r),
    .minVal  (12'd0),
    .maxVal  (MAX_Y),
    .value   (clampY_s),
    .clamped (clampedY_s)
  );

  // Position commit and single-cycle clamp indication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      posX_r    <= INIT_XC;
      posY_r    <= INIT_YC;
      edgeHit_r <= 1'b0;
    end else begin
      edgeHit_r <= commitEn_s & (clampedX_s | clampedY_s);
      if (commitEn_s) begin
        posX_r <= clampX_s;
        posY_r <= clampY_s;
      end
    end
  end

`ifdef VGA_BOX_SPRITE_BLINK_EN
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  logic [15:0] frameCnt_r;
  logic        visible_r;

  // Blink phase counter: every frame tick counts, regardless of FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frameCnt_r <= 16'd0;
      visible_r  <= 1'b1;
    end else if (frame_tick) begin
      if (frameCnt_r == BLINK_LAST) begin
        frameCnt_r <= 16'd0;
        visible_r  <= ~visible_r;
      end else begin
        frameCnt_r <= frameCnt_r + 16'd1;
      end
    end
  end

  assign visible_s = visible_r;
`else
  assign visible_s = 1'b1;
`endif

  // Strict interior test against committed position, widened to avoid wrap.
  always_comb begin
    inside_s = 1'b0;
    if (({1'b0, counterX} > {1'b0, posX_r}) &&
        ({1'b0, counterX} < ({1'b0, posX_r} + BOX_W13)) &&
        ({1'b0, counterY} > {1'b0, posY_r}) &&
        ({1'b0, counterY} < ({1'b0, posY_r} + BOX_H13))) begin
      inside_s = 1'b1;
    end else begin
      inside_s = 1'b0;
    end
  end

  // Registered pixel output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inBox_r <= 1'b0;
      vgaR_r  <= 10'd0;
      vgaG_r  <= 10'd0;
      vgaB_r  <= 10'd0;
    end else begin
      inBox_r <= inside_s;
      if (inside_s && visible_s) begin
        vgaR_r <= COLOR_R;
        vgaG_r <= COLOR_G;
        vgaB_r <= COLOR_B;
      end else begin
        vgaR_r <= 10'd0;
        vgaG_r <= 10'd0;
        vgaB_r <= 10'd0;
      end
    end
  end

  assign pos_x    = posX_r;
  assign pos_y    = posY_r;
  assign edge_hit = edgeHit_r;
  assign in_box   = inBox_r;
  assign vga_r    = vgaR_r;
  assign vga_g    = vgaG_r;
  assign vga_b    = vgaB_r;

endmodule
